id_operand_sb: RTL and testbench

//  Parametrised ID-stage operand unit: N read ports, M-deep EX/MEM/... forwarding, per-GPR

---
 rtl/id_operand_sb_pkg.sv | 17 +
 rtl/id_operand_sb_if.sv | 52 +++++
 rtl/id_operand_sb_fwd_mux.sv | 48 ++++
 rtl/id_operand_sb.sv | 118 +++++++++++
 tb/tb_id_operand_sb.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_operand_sb_pkg.sv
// Shared types and default widths for the ID-stage operand/scoreboard unit.
package id_sb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned GPR_AW_DEF = 5;

  typedef logic [GPR_AW_DEF-1:0] gpr_addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  // Where a read port's operand comes from this cycle.
  typedef enum logic [1:0] {
    SEL_FWD,
    SEL_LWB,
    SEL_GPR
  } opnd_sel_e;

endpackage

// File: rtl/id_operand_sb_if.sv
// Decoder / forwarding / writeback / EX-side signal bundle for id_operand_sb.
interface id_operand_sb_if
  import id_sb_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned GPR_AW  = GPR_AW_DEF,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
);
  logic                      dec_valid;
  logic                      dec_ready;
  logic [NUM_RD*GPR_AW-1:0]  dec_rd_addr;
  logic [NUM_RD-1:0]         dec_rd_use;
  logic [GPR_AW-1:0]         dec_dst_addr;
  logic                      dec_we_;
  logic                      dec_long;
  logic [NUM_RD*DATA_W-1:0]  gpr_rd_data;
  logic [NUM_FWD-1:0]        fwd_en;
  logic [NUM_FWD-1:0]        fwd_we_;
  logic [NUM_FWD*GPR_AW-1:0] fwd_addr;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [NUM_FWD-1:0]        fwd_ld;
  logic                      lwb_valid;
  logic [GPR_AW-1:0]         lwb_addr;
  logic [DATA_W-1:0]         lwb_data;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_RD*DATA_W-1:0]  out_opnd;
  logic [GPR_AW-1:0]         out_dst_addr;
  logic                      out_we_;
  logic                      out_long;
  logic                      sb_busy;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output dec_valid, dec_rd_addr, dec_rd_use, dec_dst_addr, dec_we_, dec_long,
           gpr_rd_data, fwd_en, fwd_we_, fwd_addr, fwd_data, fwd_ld,
           lwb_valid, lwb_addr, lwb_data, flush, out_ready,
    input  dec_ready, out_valid, out_opnd, out_dst_addr, out_we_, out_long,
           sb_busy, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_rd_addr, dec_rd_use, dec_dst_addr, dec_we_, dec_long,
           gpr_rd_data, fwd_en, fwd_we_, fwd_addr, fwd_data, fwd_ld,
           lwb_valid, lwb_addr, lwb_data, flush, out_ready,
    output dec_ready, out_valid, out_opnd, out_dst_addr, out_we_, out_long,
           sb_busy, stall_cnt
  );
endinterface

// File: rtl/id_operand_sb_fwd_mux.sv
// Per-read-port operand select: youngest matching forward source, then
// long-latency writeback, then regfile. Flags a hit on a not-yet-ready load.
module id_fwd_mux
  import id_sb_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned GPR_AW  = GPR_AW_DEF,
  parameter int unsigned NUM_FWD = 2
) (
  input  logic [GPR_AW-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         gpr_data,
  input  logic [NUM_FWD-1:0]        fwd_en,
  input  logic [NUM_FWD-1:0]        fwd_we_,
  input  logic [NUM_FWD*GPR_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_ld,
  input  logic                      lwb_valid,
  input  logic [GPR_AW-1:0]         lwb_addr,
  input  logic [DATA_W-1:0]         lwb_data,
  output logic [DATA_W-1:0]         opnd,
  output logic                      ld_hazard
);

  opnd_sel_e         sel;
  logic [DATA_W-1:0] fwd_word;

  // Scan oldest to youngest so the lowest matching index is written last and wins.
  always_comb begin
    sel       = (lwb_valid && (lwb_addr == rd_addr)) ? SEL_LWB : SEL_GPR;
    fwd_word  = '0;
    ld_hazard = 1'b0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      int unsigned j;
      j = NUM_FWD - 1 - k;
      if (fwd_en[j] && !fwd_we_[j] && (fwd_addr[j*GPR_AW +: GPR_AW] == rd_addr)) begin
        sel       = SEL_FWD;
        fwd_word  = fwd_data[j*DATA_W +: DATA_W];
        ld_hazard = fwd_ld[j];
      end
    end
    case (sel)
      SEL_FWD: opnd = fwd_word;
      SEL_LWB: opnd = lwb_data;
      default: opnd = gpr_data;
    endcase
  end

endmodule

// File: rtl/id_operand_sb.sv
// ID-stage operand unit: forwarding per read port, per-GPR scoreboard for
// long-latency results, handshaked output register to EX, stall counter.
module id_operand_sb
  import id_sb_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned GPR_AW  = GPR_AW_DEF,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
) (
  input logic           clk,
  input logic           reset_,
  id_operand_sb_if.slave bus
);

  localparam int unsigned NUM_GPR = 1 << GPR_AW;

  logic [NUM_GPR-1:0]       pending, pending_nxt;
  logic [NUM_RD-1:0]        ld_haz, port_haz;
  logic [NUM_RD*DATA_W-1:0] opnd;
  logic [GPR_AW-1:0]        rd;
  logic                     waw, hazard, ready, accept, set_pend;
  logic                     out_valid_q, out_we_q, out_long_q;
  logic [NUM_RD*DATA_W-1:0] out_opnd_q;
  logic [GPR_AW-1:0]        out_dst_q;
  logic [CNT_W-1:0]         cnt_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    id_fwd_mux #(
      .DATA_W  (DATA_W),
      .GPR_AW  (GPR_AW),
      .NUM_FWD (NUM_FWD)
    ) u_mux (
      .rd_addr   (bus.dec_rd_addr[p*GPR_AW +: GPR_AW]),
      .gpr_data  (bus.gpr_rd_data[p*DATA_W +: DATA_W]),
      .fwd_en    (bus.fwd_en),
      .fwd_we_   (bus.fwd_we_),
      .fwd_addr  (bus.fwd_addr),
      .fwd_data  (bus.fwd_data),
      .fwd_ld    (bus.fwd_ld),
      .lwb_valid (bus.lwb_valid),
      .lwb_addr  (bus.lwb_addr),
      .lwb_data  (bus.lwb_data),
      .opnd      (opnd[p*DATA_W +: DATA_W]),
      .ld_hazard (ld_haz[p])
    );
  end

  // Interlock: used sources on pending/unready-load regs, plus WAW on a pending dst.
  // A writeback arriving this cycle resolves the pending case for its address.
  always_comb begin
    port_haz = '0;
    rd       = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd = bus.dec_rd_addr[p*GPR_AW +: GPR_AW];
      port_haz[p] = bus.dec_rd_use[p] &
                    (ld_haz[p] | (pending[rd] & !(bus.lwb_valid && (bus.lwb_addr == rd))));
    end
    waw    = !bus.dec_we_ & pending[bus.dec_dst_addr] &
             !(bus.lwb_valid && (bus.lwb_addr == bus.dec_dst_addr));
    hazard = (|port_haz) | waw;
  end

  assign ready    = !hazard & !bus.flush & (!out_valid_q | bus.out_ready);
  assign accept   = bus.dec_valid & ready;
  assign set_pend = accept & bus.dec_long & !bus.dec_we_;

  // Scoreboard next state; set is applied after clear so a same-cycle set wins.
  always_comb begin
    pending_nxt = pending;
    if (bus.lwb_valid) pending_nxt[bus.lwb_addr] = 1'b0;
    if (set_pend)      pending_nxt[bus.dec_dst_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) pending <= '0;
    else         pending <= pending_nxt;
  end

  // Output register to EX: load on accept, drop on consume or flush, else hold.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      out_valid_q <= 1'b0;
      out_opnd_q  <= '0;
      out_dst_q   <= '0;
      out_we_q    <= 1'b1;
      out_long_q  <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_opnd_q  <= opnd;
      out_dst_q   <= bus.dec_dst_addr;
      out_we_q    <= bus.dec_we_;
      out_long_q  <= bus.dec_long;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating count of cycles a valid insn is held back by a data hazard.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) cnt_q <= '0;
    else if (bus.dec_valid && hazard && !bus.flush && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.dec_ready    = ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_opnd     = out_opnd_q;
  assign bus.out_dst_addr = out_dst_q;
  assign bus.out_we_      = out_we_q;
  assign bus.out_long     = out_long_q;
  assign bus.sb_busy      = |pending;
  assign bus.stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_operand_sb.sv
// Bench for id_operand_sb: vector table for operand selection plus directed
// multi-cycle sequences; accepted insns are scoreboarded against EX output.
module tb_id_operand_sb;

  logic clk = 1'b0;
  logic reset_;
  always #5 clk = ~clk;

  id_operand_sb_if #(.CNT_W(4)) bus ();

  id_operand_sb #(
    .DATA_W  (32),
    .GPR_AW  (5),
    .NUM_RD  (2),
    .NUM_FWD (2),
    .CNT_W   (4)
  ) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  typedef struct packed {
    logic [63:0] op;
    logic [4:0]  dst;
    logic        we_n;
    logic        lng;
  } exp_t;

  typedef struct {
    logic [31:0] rd0, rd1, used, fen, fwe, fa0, fa1, fd0, fd1, fld;
    logic [31:0] lv, la, ldat, g0, g1, er, e0, e1;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_stall = 0;
  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic push(input logic [31:0] op1, input logic [31:0] op0,
                      input logic [4:0] dst, input logic we_n, input logic lng);
    exp_t e;
    e.op = {op1, op0}; e.dst = dst; e.we_n = we_n; e.lng = lng;
    q.push_back(e);
  endtask

  task automatic note_stall();
    if (exp_stall < 15) exp_stall++;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.dec_valid    = 1'b0;
    bus.dec_rd_addr  = '0;
    bus.dec_rd_use   = '0;
    bus.dec_dst_addr = '0;
    bus.dec_we_      = 1'b1;
    bus.dec_long     = 1'b0;
    bus.gpr_rd_data  = '0;
    bus.fwd_en       = '0;
    bus.fwd_we_      = '1;
    bus.fwd_addr     = '0;
    bus.fwd_data     = '0;
    bus.fwd_ld       = '0;
    bus.lwb_valid    = 1'b0;
    bus.lwb_addr     = '0;
    bus.lwb_data     = '0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v);
    bus.dec_valid   = 1'b1;
    bus.dec_rd_addr = {v.rd1[4:0], v.rd0[4:0]};
    bus.dec_rd_use  = v.used[1:0];
    bus.fwd_en      = v.fen[1:0];
    bus.fwd_we_     = v.fwe[1:0];
    bus.fwd_addr    = {v.fa1[4:0], v.fa0[4:0]};
    bus.fwd_data    = {v.fd1, v.fd0};
    bus.fwd_ld      = v.fld[1:0];
    bus.lwb_valid   = v.lv[0];
    bus.lwb_addr    = v.la[4:0];
    bus.lwb_data    = v.ldat;
    bus.gpr_rd_data = {v.g1, v.g0};
  endtask

  // Scoreboard consumer: every EX handshake must match the oldest accepted insn.
  always @(negedge clk) begin
    if (reset_ && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", 64'(bus.out_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_opnd", bus.out_opnd, e.op);
        chk("sb_ctrl", 64'({bus.out_dst_addr, bus.out_we_, bus.out_long}),
            64'({e.dst, e.we_n, e.lng}));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        rd0 rd1 use fen fwe fa0 fa1 fd0        fd1        fld lv la ldat    g0          g1          er e0          e1
    tv[0]  = '{5,  6,  3,  3,  0,  5,  5,  'hAAAA,    'hBBBB,    0,  0, 0, 0,      'h100,      'h66,       1, 'hAAAA,     'h66};
    tv[1]  = '{5,  6,  3,  2,  0,  5,  5,  'hAAAA,    'hBBBB,    0,  0, 0, 0,      'h100,      'h66,       1, 'hBBBB,     'h66};
    tv[2]  = '{5,  6,  3,  3,  1,  5,  5,  'hAAAA,    'hBBBB,    0,  0, 0, 0,      'h100,      'h66,       1, 'hBBBB,     'h66};
    tv[3]  = '{5,  8,  3,  2,  0,  5,  5,  'hAAAA,    'hBBBB,    0,  1, 5, 'h5555, 'h100,      'h88,       1, 'hBBBB,     'h88};
    tv[4]  = '{6,  6,  3,  0,  3,  0,  0,  0,         0,         0,  1, 6, 'h5555, 'h100,      'h200,      1, 'h5555,     'h5555};
    tv[5]  = '{1,  2,  3,  0,  3,  0,  0,  0,         0,         0,  0, 0, 0,      'h11111111, 'h22222222, 1, 'h11111111, 'h22222222};
    tv[6]  = '{3,  4,  3,  1,  0,  3,  9,  'h3333,    'h9999,    1,  0, 0, 0,      0,          'h44,       0, 0,          0};
    tv[7]  = '{3,  4,  2,  1,  0,  3,  9,  'h3333,    'h9999,    1,  0, 0, 0,      0,          'h44,       1, 'h3333,     'h44};
    tv[8]  = '{3,  4,  3,  3,  0,  3,  3,  'h3333,    'h7777,    2,  0, 0, 0,      0,          'h44,       1, 'h3333,     'h44};
    tv[9]  = '{3,  4,  3,  3,  0,  3,  3,  'h3333,    'h7777,    1,  0, 0, 0,      0,          'h44,       0, 0,          0};
    tv[10] = '{0,  31, 3,  3,  0,  0,  31, 'hABCD,    'h31313131,0,  0, 0, 0,      'h1,        'h2,        1, 'hABCD,     'h31313131};
    tv[11] = '{7,  3,  3,  3,  0,  9,  3,  'h9,       'h3,       2,  0, 0, 0,      'h77,       0,          0, 0,          0};

    // Reset state
    reset_ = 1'b1;
    idle();
    #1 reset_ = 1'b0;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_opnd",  bus.out_opnd, 64'd0);
    chk("rst_out_ctrl",  64'({bus.out_dst_addr, bus.out_we_, bus.out_long}), 64'({5'd0, 1'b1, 1'b0}));
    chk("rst_sb_busy",   64'(bus.sb_busy), 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_ = 1'b1;

    // Operand-select table
    for (int i = 0; i < 12; i++) begin
      idle();
      apply_vec(tv[i]);
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(bus.dec_ready), 64'(tv[i].er[0]));
      if (tv[i].er[0]) push(tv[i].e1, tv[i].e0, 5'd0, 1'b1, 1'b0);
      else note_stall();
      step();
    end
    idle();
    step();
    chk("tbl_stall_cnt", 64'(bus.stall_cnt), 64'(exp_stall));

    // Load in EX: one stall, then forwards
    idle();
    bus.dec_valid = 1'b1; bus.dec_rd_addr[4:0] = 5'd3; bus.dec_rd_use = 2'b01;
    bus.fwd_en = 2'b01; bus.fwd_we_ = 2'b10; bus.fwd_addr[4:0] = 5'd3;
    bus.fwd_data[31:0] = 32'h3333; bus.fwd_ld = 2'b01;
    #1 chk("ld_stall_ready", 64'(bus.dec_ready), 64'd0);
    note_stall();
    step();
    chk("ld_stall_cnt", 64'(bus.stall_cnt), 64'(exp_stall));
    bus.fwd_ld = 2'b00;
    #1 chk("ld_fwd_ready", 64'(bus.dec_ready), 64'd1);
    push(32'd0, 32'h3333, 5'd0, 1'b1, 1'b0);
    step();

    // Long op to r7, dependent read stalls until writeback, bypassed same cycle
    idle();
    bus.dec_valid = 1'b1; bus.dec_dst_addr = 5'd7; bus.dec_we_ = 1'b0; bus.dec_long = 1'b1;
    #1 chk("long_ready", 64'(bus.dec_ready), 64'd1);
    push(32'd0, 32'd0, 5'd7, 1'b0, 1'b1);
    step();
    idle();
    chk("long_busy", 64'(bus.sb_busy), 64'd1);
    for (int k = 0; k < 4; k++) begin
      bus.dec_valid = 1'b1; bus.dec_rd_addr[4:0] = 5'd7; bus.dec_rd_use = 2'b01;
      bus.gpr_rd_data[31:0] = 32'hDEADBEEF;
      #1 chk($sformatf("pend_stall%0d", k), 64'(bus.dec_ready), 64'd0);
      note_stall();
      step();
    end
    bus.lwb_valid = 1'b1; bus.lwb_addr = 5'd7; bus.lwb_data = 32'h1234;
    #1 chk("lwb_ready", 64'(bus.dec_ready), 64'd1);
    push(32'd0, 32'h1234, 5'd0, 1'b1, 1'b0);
    step();
    idle();
    chk("lwb_busy", 64'(bus.sb_busy), 64'd0);
    chk("pend_stall_cnt", 64'(bus.stall_cnt), 64'(exp_stall));

    // Same-cycle clear and re-set of r7: set wins; then WAW stall
    bus.dec_valid = 1'b1; bus.dec_dst_addr = 5'd7; bus.dec_we_ = 1'b0; bus.dec_long = 1'b1;
    push(32'd0, 32'd0, 5'd7, 1'b0, 1'b1);
    step();
    bus.lwb_valid = 1'b1; bus.lwb_addr = 5'd7;
    #1 chk("reset_set_ready", 64'(bus.dec_ready), 64'd1);
    push(32'd0, 32'd0, 5'd7, 1'b0, 1'b1);
    step();
    idle();
    chk("set_wins_busy", 64'(bus.sb_busy), 64'd1);
    bus.dec_valid = 1'b1; bus.dec_dst_addr = 5'd7; bus.dec_we_ = 1'b0;
    #1 chk("waw_ready", 64'(bus.dec_ready), 64'd0);
    note_stall();
    step();
    idle();
    bus.lwb_valid = 1'b1; bus.lwb_addr = 5'd7;
    step();
    idle();
    chk("waw_clear_busy", 64'(bus.sb_busy), 64'd0);

    // Backpressure holds output stable; flush drops it
    bus.out_ready = 1'b0;
    bus.dec_valid = 1'b1; bus.dec_rd_addr[4:0] = 5'd10; bus.dec_rd_use = 2'b01;
    bus.gpr_rd_data[31:0] = 32'hA0A0A0A0; bus.dec_dst_addr = 5'd11; bus.dec_we_ = 1'b0;
    #1 chk("bp_first_ready", 64'(bus.dec_ready), 64'd1);
    push(32'd0, 32'hA0A0A0A0, 5'd11, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      bus.dec_rd_addr[4:0] = 5'd12; bus.gpr_rd_data[31:0] = 32'hCCCC; bus.dec_dst_addr = 5'd13;
      #1 chk($sformatf("bp_ready%0d", k), 64'(bus.dec_ready), 64'd0);
      step();
      chk($sformatf("bp_valid%0d", k), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp_opnd%0d", k), bus.out_opnd, {32'd0, 32'hA0A0A0A0});
      chk($sformatf("bp_ctrl%0d", k), 64'({bus.out_dst_addr, bus.out_we_}), 64'({5'd11, 1'b0}));
    end
    bus.flush = 1'b1;
    #1 chk("flush_ready", 64'(bus.dec_ready), 64'd0);
    step();
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    if (q.size() != 0) void'(q.pop_front());
    idle();
    step();
    chk("bp_stall_cnt", 64'(bus.stall_cnt), 64'(exp_stall));

    // Unused port on pending r9 never stalls; reset clears pending
    bus.dec_valid = 1'b1; bus.dec_dst_addr = 5'd9; bus.dec_we_ = 1'b0; bus.dec_long = 1'b1;
    push(32'd0, 32'd0, 5'd9, 1'b0, 1'b1);
    step();
    idle();
    bus.dec_valid = 1'b1; bus.dec_rd_addr = {5'd2, 5'd9}; bus.dec_rd_use = 2'b10;
    bus.gpr_rd_data = {32'h2222, 32'h0};
    #1 chk("unused_ready", 64'(bus.dec_ready), 64'd1);
    push(32'h2222, 32'd0, 5'd0, 1'b1, 1'b0);
    step();
    idle();
    step();
    chk("pre_rst_busy", 64'(bus.sb_busy), 64'd1);
    reset_ = 1'b0;
    #1;
    chk("mid_rst_busy",  64'(bus.sb_busy), 64'd0);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_cnt",   64'(bus.stall_cnt), 64'd0);
    chk("mid_rst_opnd",  bus.out_opnd, 64'd0);
    exp_stall = 0;
    step();
    reset_ = 1'b1;
    step();

    // Flush suppresses counting; counter saturates at 15
    idle();
    bus.dec_valid = 1'b1; bus.dec_rd_addr[4:0] = 5'd3; bus.dec_rd_use = 2'b01;
    bus.fwd_en = 2'b01; bus.fwd_we_ = 2'b10; bus.fwd_addr[4:0] = 5'd3; bus.fwd_ld = 2'b01;
    bus.flush = 1'b1;
    step();
    step();
    chk("flush_no_count", 64'(bus.stall_cnt), 64'd0);
    bus.flush = 1'b0;
    for (int k = 0; k < 18; k++) begin
      note_stall();
      step();
      chk($sformatf("sat%0d", k), 64'(bus.stall_cnt), 64'(exp_stall));
    end
    chk("sat_final", 64'(bus.stall_cnt), 64'd15);
    idle();
    step();
    step();
    chk("q_drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
